// File: rtl/ppu_pkg.sv
// Shared PPU/LCD constants and types used by the display-side blocks.
package ppu_pkg;
  localparam int LCD_W         = 160;
  localparam int LCD_H         = 144;
  localparam int FB_LINE_BYTES = 40;
  localparam int FB_BYTES      = 5760;
  localparam int FB_OFS_W      = 13;
  localparam int FB_ENTRY_W    = 1 + FB_OFS_W + 8;

  typedef enum logic [1:0] {PH_HBLANK, PH_VBLANK, PH_OAM, PH_DRAW} ppu_phase_t;
  typedef enum logic [1:0] {CAP_SYNC, CAP_VBLANK, CAP_CAPTURE, CAP_DRAIN} capture_state_t;

  typedef struct packed {
    logic                bank;
    logic [FB_OFS_W-1:0] ofs;
    logic [7:0]          data;
  } fb_wr_t;
endpackage

// File: rtl/fb_wr_fifo.sv
// Small write FIFO between the pixel packer and the frame buffer port.
// A push into a full FIFO succeeds when a pop happens in the same cycle.
module fb_wr_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 22
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem_q;
  logic [AW-1:0]           wp_q, rp_q;
  logic [AW:0]             cnt_q;
  logic                    do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == FULL_CNT);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign dout_o  = mem_q[rp_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wp_q] <= din_i;
        wp_q        <= wp_q + AW'(1);
      end
      if (do_pop) rp_q <= rp_q + AW'(1);
      cnt_q <= cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end
endmodule

// File: rtl/lcd_frame_capture.sv
// Captures the PPU pixel stream into a double-buffered 2bpp frame buffer,
// packing four pixels per byte and flipping banks once a frame has drained.
module lcd_frame_capture
  import ppu_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lcd_hsync,
  input  logic        lcd_vsync,
  input  logic        lcd_pixel,
  input  logic [1:0]  lcd_color,
  output logic [13:0] fb_addr,
  output logic [7:0]  fb_data,
  output logic        fb_we,
  input  logic        fb_ready,
  output logic        frame_bank,
  output logic        frame_done,
  output logic        line_err,
  output logic        frame_err,
  output logic        ovf_err,
  input  logic        err_clr
);
  localparam logic [7:0]  X_END   = 8'(LCD_W);
  localparam logic [7:0]  Y_END   = 8'(LCD_H);
  localparam logic [12:0] LINE_B  = 13'(FB_LINE_BYTES);
  localparam logic [12:0] OFS_MAX = 13'(FB_BYTES - 1);

  capture_state_t state_q, state_d;
  logic        hs_q, vs_q;
  logic [7:0]  x_q, x_d, y_q, y_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [5:0]  pack_q, pack_d;
  logic [12:0] ptr_q, ptr_d, base_q, base_d;
  logic        bank_q, done_q, lerr_q, ferr_q, oerr_q;

  logic   hs_rise, vs_rise, vs_fall, pix_ok;
  logic   cap_start, cap_en, drain_done;
  logic   push, pop, set_line, set_frame, set_ovf;
  logic   fifo_full, fifo_empty;
  fb_wr_t push_ent, head;

  assign hs_rise = lcd_hsync & ~hs_q;
  assign vs_rise = lcd_vsync & ~vs_q;
  assign vs_fall = ~lcd_vsync & vs_q;
  // A strobe coincident with a sync rise still counts; only strobes inside a blank are ignored.
  assign pix_ok  = lcd_pixel & ~(lcd_hsync & hs_q) & ~(lcd_vsync & vs_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= CAP_SYNC;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CAP_SYNC:    if (vs_rise)    state_d = CAP_VBLANK;
      CAP_VBLANK:  if (vs_fall)    state_d = CAP_CAPTURE;
      CAP_CAPTURE: if (vs_rise)    state_d = CAP_DRAIN;
      CAP_DRAIN:   if (fifo_empty) state_d = CAP_VBLANK;
      default:                     state_d = CAP_SYNC;
    endcase
  end

  always_comb begin
    cap_start  = (state_q == CAP_VBLANK) && vs_fall;
    cap_en     = (state_q == CAP_CAPTURE);
    drain_done = (state_q == CAP_DRAIN) && fifo_empty;
  end

  always_comb begin
    x_d = x_q; y_d = y_q; cnt_d = cnt_q; pack_d = pack_q;
    ptr_d = ptr_q; base_d = base_q;
    push = 1'b0; set_line = 1'b0; set_frame = 1'b0;
    push_ent.bank = bank_q;
    push_ent.ofs  = ptr_q;
    push_ent.data = {pack_q, lcd_color};
    if (cap_start) begin
      x_d = '0; y_d = '0; cnt_d = '0; pack_d = '0; ptr_d = '0; base_d = '0;
    end else if (cap_en) begin
      if (pix_ok) begin
        if (x_q < X_END && y_q < Y_END) begin
          x_d    = x_q + 8'd1;
          cnt_d  = cnt_q + 2'd1;
          pack_d = {pack_q[3:0], lcd_color};
          if (cnt_q == 2'd3) begin
            if (ptr_q <= OFS_MAX) begin
              push  = 1'b1;
              ptr_d = ptr_q + 13'd1;
            end else begin
              set_line = 1'b1;
            end
          end
        end else begin
          set_line = 1'b1;
        end
      end
      // Realigning to the next line base also covers the short-line case.
      if (hs_rise) begin
        if (x_d != X_END || y_q >= Y_END) set_line = 1'b1;
        if (y_q < Y_END) begin
          ptr_d  = base_q + LINE_B;
          base_d = base_q + LINE_B;
        end
        y_d    = (y_q == 8'hFF) ? y_q : y_q + 8'd1;
        x_d    = '0;
        cnt_d  = '0;
        pack_d = '0;
      end
      if (vs_rise && y_d != Y_END) set_frame = 1'b1;
    end
  end

  assign pop     = ~fifo_empty & fb_ready;
  assign set_ovf = push & fifo_full & ~pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q <= 1'b0; vs_q <= 1'b0;
      x_q <= '0; y_q <= '0; cnt_q <= '0; pack_q <= '0;
      ptr_q <= '0; base_q <= '0;
      bank_q <= 1'b0; done_q <= 1'b0;
      lerr_q <= 1'b0; ferr_q <= 1'b0; oerr_q <= 1'b0;
    end else begin
      hs_q <= lcd_hsync; vs_q <= lcd_vsync;
      x_q <= x_d; y_q <= y_d; cnt_q <= cnt_d; pack_q <= pack_d;
      ptr_q <= ptr_d; base_q <= base_d;
      bank_q <= bank_q ^ drain_done;
      done_q <= drain_done;
      lerr_q <= set_line  | (lerr_q & ~err_clr);
      ferr_q <= set_frame | (ferr_q & ~err_clr);
      oerr_q <= set_ovf   | (oerr_q & ~err_clr);
    end
  end

  fb_wr_fifo #(.DEPTH(FIFO_DEPTH), .W(FB_ENTRY_W)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .din_i   (push_ent),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign fb_we      = ~fifo_empty;
  assign fb_addr    = {head.bank, head.ofs};
  assign fb_data    = head.data;
  assign frame_bank = bank_q;
  assign frame_done = done_q;
  assign line_err   = lerr_q;
  assign frame_err  = ferr_q;
  assign ovf_err    = oerr_q;
endmodule

// File: tb/tb_lcd_frame_capture.sv
// Scenario bench for lcd_frame_capture: expected frame-buffer writes come from
// a line/pixel model (offset = line*40 + byte index, four pixels per byte).
module tb_lcd_frame_capture;
  logic clk = 1'b0, rst_n = 1'b0;
  logic lcd_hsync = 1'b0, lcd_vsync = 1'b0, lcd_pixel = 1'b0, fb_ready = 1'b0, err_clr = 1'b0;
  logic [1:0]  lcd_color = 2'd0;
  logic [13:0] fb_addr;
  logic [7:0]  fb_data;
  logic        fb_we, frame_bank, frame_done, line_err, frame_err, ovf_err;

  int pass_cnt = 0, total_cnt = 0;
  int done_cnt = 0, wr_at_done = -1;
  bit tog = 1'b0;
  logic [21:0] exp_q[$];
  logic [21:0] act_q[$];

  always #5 clk = ~clk;

  lcd_frame_capture #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .lcd_hsync(lcd_hsync), .lcd_vsync(lcd_vsync),
    .lcd_pixel(lcd_pixel), .lcd_color(lcd_color), .fb_addr(fb_addr), .fb_data(fb_data),
    .fb_we(fb_we), .fb_ready(fb_ready), .frame_bank(frame_bank), .frame_done(frame_done),
    .line_err(line_err), .frame_err(frame_err), .ovf_err(ovf_err), .err_clr(err_clr)
  );

  // Inputs only change just after posedge, so negedge values are what the next edge accepts.
  always @(negedge clk) begin
    if (rst_n && fb_we && fb_ready) act_q.push_back({fb_addr, fb_data});
    if (frame_done) begin
      done_cnt++;
      wr_at_done = act_q.size();
    end
  end

  task automatic tick();
    @(posedge clk); #1;
    if (tog) fb_ready = ~fb_ready;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; tog = 1'b0;
    lcd_hsync = 1'b0; lcd_vsync = 1'b0; lcd_pixel = 1'b0; err_clr = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  // One line of n pixels then a 1-cycle hsync; model expects whole groups of 4 within 160.
  task automatic send_line(input int n, input bit rnd, input int y, input bit bank, input int clr_at);
    logic [1:0] c[$];
    logic [1:0] col;
    logic [7:0] b;
    int nb;
    for (int i = 0; i < n; i++) begin
      col = rnd ? 2'($urandom_range(0, 3)) : 2'(i % 4);
      c.push_back(col);
      lcd_pixel = 1'b1; lcd_color = col; err_clr = (i == clr_at);
      tick();
    end
    lcd_pixel = 1'b0; err_clr = 1'b0; lcd_hsync = 1'b1;
    tick();
    lcd_hsync = 1'b0;
    nb = ((n > 160) ? 160 : n) / 4;
    if (y < 144)
      for (int k = 0; k < nb; k++) begin
        b = {c[4*k], c[4*k+1], c[4*k+2], c[4*k+3]};
        exp_q.push_back({bank, 13'(y*40 + k), b});
      end
  endtask

  task automatic start_frame();
    lcd_vsync = 1'b1; tick(); tick();
    lcd_vsync = 1'b0; tick();
    act_q.delete(); exp_q.delete();
    done_cnt = 0; wr_at_done = -1;
  endtask

  task automatic end_frame();
    int t = 0;
    lcd_vsync = 1'b1;
    while (done_cnt == 0 && t < 200) begin tick(); t++; end
    tick(); tick();
  endtask

  function automatic int first_bad();
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++)
      if (act_q[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; fb_ready = 1'b1;
    tick(); tick();
    total_cnt++; if (fb_we !== 1'b0) $display("FAIL reset fb_we: got %b want 0", fb_we); else pass_cnt++;
    total_cnt++; if ({fb_addr, fb_data} !== 22'd0) $display("FAIL reset addr/data: got %h/%h want 0", fb_addr, fb_data); else pass_cnt++;
    total_cnt++; if ({frame_bank, frame_done} !== 2'b00) $display("FAIL reset bank/done: got %b%b want 00", frame_bank, frame_done); else pass_cnt++;
    total_cnt++; if ({line_err, frame_err, ovf_err} !== 3'b000) $display("FAIL reset errs: got %b%b%b want 000", line_err, frame_err, ovf_err); else pass_cnt++;
    rst_n = 1'b1; tick();
    act_q.delete(); exp_q.delete();
    send_line(16, 1'b1, 200, 1'b0, -1);
    tick(); tick();
    total_cnt++; if (act_q.size() !== 0) $display("FAIL sync_discard: got %0d writes want 0", act_q.size()); else pass_cnt++;
  endtask

  task automatic test_full_frame();
    int fb;
    apply_reset();
    fb_ready = 1'b1;
    start_frame();
    for (int y = 0; y < 144; y++) send_line(160, 1'b0, y, 1'b0, -1);
    end_frame();
    fb = first_bad();
    total_cnt++; if (act_q.size() !== 5760) $display("FAIL full_frame count: got %0d want 5760", act_q.size()); else pass_cnt++;
    total_cnt++; if (fb != -1) $display("FAIL full_frame write %0d: got %h want %h", fb, act_q[fb], exp_q[fb]); else pass_cnt++;
    total_cnt++; if (done_cnt !== 1) $display("FAIL full_frame done pulses: got %0d want 1", done_cnt); else pass_cnt++;
    total_cnt++; if (frame_bank !== 1'b1) $display("FAIL full_frame bank: got %b want 1", frame_bank); else pass_cnt++;
    total_cnt++; if ({line_err, frame_err, ovf_err} !== 3'b000) $display("FAIL full_frame errs: got %b%b%b want 000", line_err, frame_err, ovf_err); else pass_cnt++;
  endtask

  task automatic test_overflow();
    logic [1:0] c[20];
    int fb;
    apply_reset();
    fb_ready = 1'b0;
    start_frame();
    for (int i = 0; i < 20; i++) begin
      c[i] = 2'($urandom_range(0, 3));
      lcd_pixel = 1'b1; lcd_color = c[i];
      tick();
    end
    lcd_pixel = 1'b0;
    for (int k = 0; k < 4; k++) exp_q.push_back({1'b0, 13'(k), c[4*k], c[4*k+1], c[4*k+2], c[4*k+3]});
    tick();
    total_cnt++; if (ovf_err !== 1'b1) $display("FAIL ovf flag: got %b want 1", ovf_err); else pass_cnt++;
    total_cnt++; if (fb_we !== 1'b1) $display("FAIL ovf fb_we: got %b want 1", fb_we); else pass_cnt++;
    repeat (5) tick();
    total_cnt++; if ({fb_addr, fb_data} !== exp_q[0]) $display("FAIL ovf head stable: got %h want %h", {fb_addr, fb_data}, exp_q[0]); else pass_cnt++;
    fb_ready = 1'b1;
    repeat (10) tick();
    fb_ready = 1'b0;
    fb = first_bad();
    total_cnt++; if (act_q.size() !== 4) $display("FAIL ovf drain count: got %0d want 4", act_q.size()); else pass_cnt++;
    total_cnt++; if (fb != -1) $display("FAIL ovf drain write %0d: got %h want %h", fb, act_q[fb], exp_q[fb]); else pass_cnt++;
    total_cnt++; if (line_err !== 1'b0) $display("FAIL ovf line_err: got %b want 0", line_err); else pass_cnt++;
  endtask

  task automatic test_short_line();
    int fb;
    apply_reset();
    fb_ready = 1'b1;
    start_frame();
    send_line(158, 1'b1, 0, 1'b0, -1);
    tick();
    total_cnt++; if (line_err !== 1'b1) $display("FAIL short_line flag: got %b want 1", line_err); else pass_cnt++;
    send_line(160, 1'b1, 1, 1'b0, -1);
    repeat (4) tick();
    total_cnt++;
    if (act_q.size() < 40 || act_q[39][21:8] !== 14'd40)
      $display("FAIL short_line realign: got size %0d addr %h want addr 0028", act_q.size(), (act_q.size() >= 40) ? act_q[39][21:8] : 14'h3fff);
    else pass_cnt++;
    err_clr = 1'b1; tick(); err_clr = 1'b0; tick();
    total_cnt++; if (line_err !== 1'b0) $display("FAIL err_clr: got %b want 0", line_err); else pass_cnt++;
    send_line(161, 1'b1, 2, 1'b0, 160);
    repeat (4) tick();
    total_cnt++; if (line_err !== 1'b1) $display("FAIL clr_vs_event: got %b want 1", line_err); else pass_cnt++;
    fb = first_bad();
    total_cnt++; if (act_q.size() !== 119) $display("FAIL short_line count: got %0d want 119", act_q.size()); else pass_cnt++;
    total_cnt++; if (fb != -1) $display("FAIL short_line write %0d: got %h want %h", fb, act_q[fb], exp_q[fb]); else pass_cnt++;
    total_cnt++; if (frame_err !== 1'b0) $display("FAIL short_line frame_err: got %b want 0", frame_err); else pass_cnt++;
  endtask

  task automatic test_reset_midframe();
    int fb;
    apply_reset();
    fb_ready = 1'b1;
    start_frame();
    for (int y = 0; y < 70; y++) send_line(160, 1'b1, y, 1'b0, -1);
    #3 rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    total_cnt++; if (frame_bank !== 1'b0) $display("FAIL midreset bank: got %b want 0", frame_bank); else pass_cnt++;
    act_q.delete();
    send_line(160, 1'b1, 200, 1'b0, -1);
    repeat (4) tick();
    total_cnt++; if (act_q.size() !== 0) $display("FAIL midreset ignore: got %0d writes want 0", act_q.size()); else pass_cnt++;
    total_cnt++; if (done_cnt !== 0) $display("FAIL midreset done: got %0d pulses want 0", done_cnt); else pass_cnt++;
    tog = 1'b1;
    start_frame();
    for (int y = 0; y < 144; y++) send_line(160, 1'b1, y, 1'b0, -1);
    end_frame();
    tog = 1'b0; fb_ready = 1'b1;
    fb = first_bad();
    total_cnt++; if (act_q.size() !== 5760) $display("FAIL toggle count: got %0d want 5760", act_q.size()); else pass_cnt++;
    total_cnt++; if (fb != -1) $display("FAIL toggle write %0d: got %h want %h", fb, act_q[fb], exp_q[fb]); else pass_cnt++;
    total_cnt++; if (wr_at_done !== 5760) $display("FAIL toggle done_after_last: got %0d writes at done want 5760", wr_at_done); else pass_cnt++;
    total_cnt++; if (done_cnt !== 1) $display("FAIL toggle done pulses: got %0d want 1", done_cnt); else pass_cnt++;
    total_cnt++; if (ovf_err !== 1'b0) $display("FAIL toggle ovf: got %b want 0", ovf_err); else pass_cnt++;
    total_cnt++; if (frame_bank !== 1'b1) $display("FAIL toggle bank: got %b want 1", frame_bank); else pass_cnt++;
  endtask

  task automatic test_short_frame();
    int fb;
    fb_ready = 1'b1;
    start_frame();
    for (int y = 0; y < 100; y++) send_line(160, 1'b1, y, 1'b1, -1);
    end_frame();
    fb = first_bad();
    total_cnt++; if (frame_err !== 1'b1) $display("FAIL short_frame flag: got %b want 1", frame_err); else pass_cnt++;
    total_cnt++; if (done_cnt !== 1) $display("FAIL short_frame done: got %0d want 1", done_cnt); else pass_cnt++;
    total_cnt++; if (frame_bank !== 1'b0) $display("FAIL short_frame bank: got %b want 0", frame_bank); else pass_cnt++;
    total_cnt++; if (act_q.size() !== 4000) $display("FAIL short_frame count: got %0d want 4000", act_q.size()); else pass_cnt++;
    total_cnt++; if (fb != -1) $display("FAIL short_frame write %0d: got %h want %h", fb, act_q[fb], exp_q[fb]); else pass_cnt++;
    total_cnt++; if (line_err !== 1'b0) $display("FAIL short_frame line_err: got %b want 0", line_err); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_overflow();
    test_short_line();
    test_reset_midframe();
    test_short_frame();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
